uart_tx_arbiter: RTL and testbench

//  Shares the UART TX path between NumReq byte producers (core printf shim, trace, debug).

---
 rtl/uart_pkg.sv | 56 +++++
 rtl/uart_tx_arbiter_if.sv | 15 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART register map, arbiter state encoding and device-access payload
// used by the UART TX arbiter slice.
package uart_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned ByteW = 8;
  localparam int unsigned BeW   = 4;

  localparam logic [AddrW-1:0] UART_RX_REG     = 32'h0000_0000;
  localparam logic [AddrW-1:0] UART_TX_REG     = 32'h0000_0004;
  localparam logic [AddrW-1:0] UART_STATUS_REG = 32'h0000_0008;

  localparam int unsigned STATUS_TX_FULL_BIT  = 1;
  localparam int unsigned STATUS_RX_EMPTY_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    ST_RD,
    ST_WAIT,
    GAP,
    WR,
    WR_WAIT
  } uart_arb_state_t;

  // One single-cycle device access as presented on the bus
  typedef struct packed {
    logic             req;
    logic [AddrW-1:0] addr;
    logic             we;
    logic [BeW-1:0]   be;
    logic [DataW-1:0] wdata;
  } uart_acc_t;

  function automatic uart_acc_t status_read(input logic [AddrW-1:0] base);
    uart_acc_t a;
    a      = '0;
    a.req  = 1'b1;
    a.addr = base + UART_STATUS_REG;
    a.be   = 4'b0001;
    return a;
  endfunction

  function automatic uart_acc_t tx_write(input logic [AddrW-1:0] base,
                                         input logic [ByteW-1:0] b);
    uart_acc_t a;
    a       = '0;
    a.req   = 1'b1;
    a.addr  = base + UART_TX_REG;
    a.we    = 1'b1;
    a.be    = 4'b0001;
    a.wdata = {24'h00_0000, b};
    return a;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// UART device port: single-cycle request, response flagged by rvalid.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic             req;
  logic [AddrW-1:0] addr;
  logic             we;
  logic [BeW-1:0]   be;
  logic [DataW-1:0] wdata;
  logic             rvalid;
  logic [DataW-1:0] rdata;

  modport master (output req, addr, we, be, wdata, input rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output rvalid, rdata);
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IdxW'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX register between NumReq byte producers;
// each accepted byte polls STATUS until the TX FIFO has room, then is written.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned      NumReq   = 4,
  parameter  logic [AddrW-1:0] BaseAddr = 32'h0,
  parameter  int unsigned      PollGap  = 8,
  localparam int unsigned      IdxW     = $clog2(NumReq),
  localparam int unsigned      CntW     = $clog2(PollGap + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*ByteW-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  uart_tx_arbiter_if.master       uart,
  output logic                    busy_o,
  output logic [IdxW-1:0]         grant_idx_o
);

  uart_arb_state_t state_q;
  logic [IdxW-1:0] ptr_q, gidx_q, gnt_idx, ptr_next;
  logic [NumReq-1:0] gnt;
  logic            gnt_valid;
  logic [ByteW-1:0] byte_q, gnt_byte;
  logic [CntW-1:0] cnt_q;
  uart_acc_t       acc_q;
  logic            busy_q;
  logic            unused_rdata;

  rr_arbiter #(.N(NumReq)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign gnt_byte = req_data_i[{gnt_idx, 3'b000} +: ByteW];
  assign ptr_next = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);

  // The handshake must land in the same cycle the arbiter decides, so ready is a decode
  assign req_ready_o = (state_q == IDLE) ? gnt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            byte_q  <= gnt_byte;
            gidx_q  <= gnt_idx;
            ptr_q   <= ptr_next;
            busy_q  <= 1'b1;
            acc_q   <= status_read(BaseAddr);
            state_q <= ST_RD;
          end
        end
        ST_RD: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (uart.rvalid) begin
            if (uart.rdata[STATUS_TX_FULL_BIT]) begin
              cnt_q   <= CntW'(PollGap - 1);
              state_q <= GAP;
            end else begin
              acc_q   <= tx_write(BaseAddr, byte_q);
              state_q <= WR;
            end
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            acc_q   <= status_read(BaseAddr);
            state_q <= ST_RD;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        WR: state_q <= WR_WAIT;
        WR_WAIT: begin
          if (uart.rvalid) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign uart.req     = acc_q.req;
  assign uart.addr    = acc_q.addr;
  assign uart.we      = acc_q.we;
  assign uart.be      = acc_q.be;
  assign uart.wdata   = acc_q.wdata;
  assign busy_o       = busy_q;
  assign grant_idx_o  = gidx_q;
  assign unused_rdata = ^uart.rdata;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of single-byte transactions plus
// hand-written round-robin streaming and reset-during-GAP sequences.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned PollGap = 8;
  localparam logic [31:0] Base    = 32'h4000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        busy;
  logic [1:0]  gidx;

  uart_tx_arbiter_if uart();

  uart_tx_arbiter #(.NumReq(NumReq), .BaseAddr(Base), .PollGap(PollGap)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .uart        (uart),
    .busy_o      (busy),
    .grant_idx_o (gidx)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Device model: responds dev_lat cycles after each request; first full_left STATUS reads report full
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  acc_t        log_q[$];
  int          dev_lat = 1;
  int          full_left = 0;
  int          pend = 0;
  logic [31:0] pend_rd = '0;

  always @(negedge clk_i) begin
    uart.rvalid = 1'b0;
    uart.rdata  = '0;
    if (!rst_ni) begin
      pend = 0;
    end else begin
      if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          uart.rvalid = 1'b1;
          uart.rdata  = pend_rd;
        end
      end
      if (uart.req === 1'b1) begin
        chk("single_outstanding", 32'(pend != 0), 32'd0);
        log_q.push_back('{cyc, uart.addr, uart.we, uart.be, uart.wdata});
        pend = dev_lat;
        if (uart.we) pend_rd = 32'h0;
        else if (full_left > 0) begin
          full_left--;
          pend_rd = 32'h0000_0003;
        end else pend_rd = 32'hFFFF_FFFD;
      end
    end
  end

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          full;
    int          lat;
    int          g;
    int          nrd;
    int          woff;
    int          idle;
  } vec_t;

  vec_t vecs[9];

  task automatic wait_idle(output int t_done);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    t_done = cyc;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int t0, t_idle, nrd, nwr, wi;
    logic [31:0] d;
    d = v.data;
    @(negedge clk_i);
    log_q.delete();
    full_left = v.full;
    dev_lat   = v.lat;
    req_valid = v.mask;
    req_data  = v.data;
    #1;
    chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(1 << v.g));
    t0 = cyc;
    @(negedge clk_i);
    req_valid = '0;
    #1;
    chk($sformatf("v%0d_grant_idx", n), 32'(gidx), 32'(v.g));
    chk($sformatf("v%0d_busy", n), 32'(busy), 32'd1);
    wait_idle(t_idle);
    chk($sformatf("v%0d_idle_cycle", n), 32'(t_idle - t0), 32'(v.idle));
    nrd = 0;
    nwr = 0;
    wi  = -1;
    foreach (log_q[i]) begin
      if (log_q[i].we) begin
        nwr++;
        wi = i;
      end else nrd++;
    end
    chk($sformatf("v%0d_reads", n), 32'(nrd), 32'(v.nrd));
    chk($sformatf("v%0d_writes", n), 32'(nwr), 32'd1);
    if (log_q.size() > 0) begin
      chk($sformatf("v%0d_rd_cycle", n), 32'(log_q[0].cyc - t0), 32'd1);
      chk($sformatf("v%0d_rd_addr", n), log_q[0].addr, Base + 32'h8);
      chk($sformatf("v%0d_rd_be", n), 32'(log_q[0].be), 32'h1);
    end
    if (wi >= 0) begin
      chk($sformatf("v%0d_wr_cycle", n), 32'(log_q[wi].cyc - t0), 32'(v.woff));
      chk($sformatf("v%0d_wr_addr", n), log_q[wi].addr, Base + 32'h4);
      chk($sformatf("v%0d_wr_data", n), log_q[wi].wdata, {24'h0, d[v.g*8 +: 8]});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req"}, 32'(uart.req), 32'd0);
    chk({tag, "_we"}, 32'(uart.we), 32'd0);
    chk({tag, "_be"}, 32'(uart.be), 32'd0);
    chk({tag, "_addr"}, uart.addr, 32'd0);
    chk({tag, "_wdata"}, uart.wdata, 32'd0);
    chk({tag, "_gidx"}, 32'(gidx), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, tprev, t_idle, wi;
    int          exp_order[5];
    logic [7:0]  exp_bytes[5];

    //            mask   data           full lat g nrd woff idle
    vecs[0] = '{4'b0001, 32'h0000_0041, 0, 1, 0, 1,  3,  5};
    vecs[1] = '{4'b1111, 32'h1312_1110, 0, 1, 1, 1,  3,  5};
    vecs[2] = '{4'b1001, 32'h2322_2120, 0, 1, 3, 1,  3,  5};
    vecs[3] = '{4'b1111, 32'h3332_3130, 0, 1, 0, 1,  3,  5};
    vecs[4] = '{4'b0100, 32'h0042_0000, 3, 1, 2, 4, 33, 35};
    vecs[5] = '{4'b0100, 32'h0043_0000, 0, 4, 2, 1,  6, 11};
    vecs[6] = '{4'b1010, 32'h5400_5100, 0, 1, 3, 1,  3,  5};
    vecs[7] = '{4'b0110, 32'h0062_6100, 0, 1, 1, 1,  3,  5};
    vecs[8] = '{4'b0011, 32'h0000_7170, 0, 1, 0, 1,  3,  5};

    repeat (3) @(negedge clk_i);
    #1;
    check_outputs_zero("reset");
    chk("reset_ready", 32'(req_ready), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while polling a full FIFO (pointer is 1 here, so req1 is granted)
    @(negedge clk_i);
    log_q.delete();
    full_left = 1000;
    dev_lat   = 1;
    req_valid = 4'b0010;
    req_data  = 32'h0000_5500;
    #1;
    chk("gap_ready", 32'(req_ready), 32'h2);
    @(negedge clk_i);
    req_valid = '0;
    repeat (4) @(negedge clk_i);
    #1;
    chk("gap_busy_before_reset", 32'(busy), 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk_i);
    full_left = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // All requesters streaming: pointer restarts at 0 after reset
    exp_order = '{0, 1, 2, 3, 0};
    exp_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    @(negedge clk_i);
    log_q.delete();
    dev_lat   = 1;
    req_data  = 32'hA3A2_A1A0;
    req_valid = 4'hF;
    #1;
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      while (req_ready == '0 && t < 50) begin
        @(negedge clk_i);
        #1;
        t++;
      end
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << exp_order[k]));
      if (k > 0) chk($sformatf("rr%0d_spacing", k), 32'(cyc - tprev), 32'd5);
      tprev = cyc;
      @(negedge clk_i);
      req_data[exp_order[k]*8 +: 8] = 8'hB0 + 8'(exp_order[k]);
      if (k == 4) req_valid = '0;
      #1;
    end
    wait_idle(t_idle);
    chk("rr_idle", 32'(busy), 32'd0);
    wi = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we) begin
        if (wi < 5) chk($sformatf("rr_wdata%0d", wi), log_q[i].wdata, {24'h0, exp_bytes[wi]});
        wi++;
      end
    end
    chk("rr_writes", 32'(wi), 32'd5);
    t0 = log_q.size();
    chk("rr_accesses", 32'(t0), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
